// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage owning the fetch PC. Reads instruction words
// from memory port 0 and buffers {pc, instr} pairs in a small FIFO whose head is
// presented to issue with a valid/ready handshake. A redirect flushes the queue
// and restarts fetch at the new address.
// Optional build macro FETCH_STATS_EN adds fetched_count / flushed_count outputs.
module instr_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_en,
   output logic [31:0]        mem_raddr,
   input  logic [31:0]        mem_rdata,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_addr,
   input  logic               issue_ready,
   output logic               instr_valid,
   output logic [31:0]        instr,
   output logic [31:0]        instr_pc,
   output logic [PTR_W:0]     occupancy
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        fetched_count,
   output logic [31:0]        flushed_count
`endif
);

   localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

   logic [31:0]      r_fetch_pc;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_occ;
   logic [31:0]      r_pc_q  [DEPTH];
   logic [31:0]      r_ins_q [DEPTH];

   logic             w_valid;
   logic             w_pop;
   logic             w_push;

   // Empty/partial/full is derived from occupancy alone; no separate full flag.
   assign w_valid   = (r_occ != '0);
   assign w_pop     = w_valid & issue_ready;
   assign w_push    = fetch_en & ~redirect_valid & ((r_occ < C_DEPTH) | w_pop);

   assign mem_raddr = r_fetch_pc;
   assign occupancy = r_occ;

   // Head entry drives the issue outputs directly; zeros (no-op) when empty.
   always_comb begin
      instr_valid = w_valid;
      instr       = '0;
      instr_pc    = '0;
      if (w_valid) begin
         instr    = r_ins_q[r_rptr];
         instr_pc = r_pc_q[r_rptr];
      end
   end

   // Fetch PC, pointers and occupancy; redirect overrides any push or pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_occ      <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_addr;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_occ      <= '0;
      end else begin
         if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd1;
            r_wptr     <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Queue storage; contents are don't-care out of reset, so no reset here.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_q[r_wptr]  <= r_fetch_pc;
         r_ins_q[r_wptr] <= mem_rdata;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] r_fetched;
   logic [31:0] r_flushed;
   logic [32:0] w_flush_sum;

   assign w_flush_sum   = {1'b0, r_flushed} + 33'(r_occ);
   assign fetched_count = r_fetched;
   assign flushed_count = r_flushed;

   // Saturating statistics: pushes seen, and entries discarded by redirects.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetched <= '0;
         r_flushed <= '0;
      end else begin
         if (w_push && (r_fetched != '1)) begin
            r_fetched <= r_fetched + 32'd1;
         end
         if (redirect_valid) begin
            r_flushed <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
         end
      end
   end
`endif

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Fetch stage for the pipelined CPU. It owns the fetch PC, reads instruction words from main-memory read port 0, and buffers {pc, instruction} pairs in a small FIFO. It presents the FIFO head to the issue register using a valid/ready handshake. Stall from the stall detector appears as ready deasserted; jumps resolved downstream arrive as a redirect that flushes the queue.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2.
PTR_W, 2, log2(DEPTH); pointer width.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
fetch_en  input  1  fetch enable; when 0, no new fetches (queue still drains)
mem_raddr  output  32  read address to main memory port 0; equals fetch_pc
mem_rdata  input  32  read data from port 0; combinational, same cycle as mem_raddr
redirect_valid  input  1  jump taken; flush and restart fetch
redirect_addr  input  32  new fetch address
issue_ready  input  1  issue register accepts this cycle (!stall)
instr_valid  output  1  queue head valid
instr  output  32  queue head instruction; 32'h0 (no-op) when empty
instr_pc  output  32  PC of queue head; 0 when empty
occupancy  output  PTR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=0; read and write pointers = 0; occupancy=0.
  - instr_valid=0, instr=0, instr_pc=0.
  - Queue storage contents are don't-care.
- Outputs:
  - mem_raddr = fetch_pc, combinationally.
  - instr, instr_pc and instr_valid come from the head entry, combinationally; no skid register.
- pop = instr_valid & issue_ready.
  - Pop when empty is impossible, because instr_valid=0 when empty.
- push = fetch_en & !redirect_valid & (occupancy<DEPTH | pop).
  - Full and popping in the same cycle means push-through: occupancy stays at DEPTH.
- On push, at the clock edge:
  - Entry at the write pointer <= {fetch_pc, mem_rdata}.
  - Write pointer += 1, modulo DEPTH.
  - fetch_pc += 1; this is a word address and wraps from 32'hFFFFFFFF to 0.
- On pop: read pointer += 1, modulo DEPTH.
- Occupancy: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a word fetched in cycle N is visible at the head in cycle N+1 when the queue was empty. There is no bypass from mem_rdata to instr.
- Redirect (highest priority), when redirect_valid=1 at the clock edge:
  - Both pointers are reset to 0 and occupancy to 0.
  - fetch_pc <= redirect_addr.
  - No push that cycle; any pop is ignored.
  - In the cycle after, instr_valid=0, and the first word from redirect_addr is pushed.
  - Back-to-back redirects: the last one wins; the queue stays empty.
- fetch_en=0: fetch_pc is held and there are no pushes. Pops continue until empty.
- Full and issue_ready=0: fetch_pc is held and mem_raddr stays constant.
- Reset asserted mid-operation: immediate return to the reset state. The first fetch after release is from address 0.
- State: no explicit FSM. The queue is EMPTY / PARTIAL / FULL, derived from occupancy. A separate full flag is not permitted.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, the block adds two outputs:
  - fetched_count, 32 bits: increments on each push.
  - flushed_count, 32 bits: adds the pre-flush occupancy on each redirect.
- Both counters reset to 0 and saturate at 32'hFFFFFFFF.
- When not defined, neither port nor counter exists, and all other behaviour is identical.

Test Plan:
1. Reset, then release with fetch_en=1 and issue_ready=1, memory[i]=i+100.
   - instr_valid rises 1 cycle after release.
   - instr = 100, 101, 102, ... on consecutive cycles, with instr_pc = 0, 1, 2.
   - occupancy holds at 1.
2. issue_ready=0 for 8 cycles.
   - occupancy climbs 1, 2, 3, 4 and then holds at 4.
   - mem_raddr holds at 4.
   - Release issue_ready: instr = 100..103 in order, then 104 with no gap.
3. Queue full (occupancy 4) with one cycle of issue_ready=1.
   - Push-through: occupancy stays 4; head advances from 100 to 101; fetch_pc advances by 1.
4. redirect_valid=1 with redirect_addr=32'h40 while occupancy=3.
   - Next cycle: instr_valid=0, instr=0, occupancy=0, mem_raddr=32'h40.
   - Cycle after: instr_pc=32'h40.
   - With FETCH_STATS_EN defined: flushed_count=3.
5. fetch_pc=32'hFFFFFFFF with a push.
   - fetch_pc wraps to 0; the entry carries instr_pc=32'hFFFFFFFF, and the next entry has instr_pc=0.
6. rst asserted asynchronously mid-stream with occupancy=2.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, the first instr_pc is 0.
